usb_fs_tx_serializer: RTL and testbench
=======================================

# usb_fs_tx_serializer

Full-speed USB transmit serializer, directly downstream of the IN protocol engine. It accepts a packet-start strobe and PID, pulls payload bytes through the `tx_data_avail`/`tx_data_get`/`tx_data` handshake, and appends CRC16 to data packets. It drives a bit-stuffed, NRZI-encoded 12 Mb/s differential line with SYNC and EOP, clocked from 48 MHz with 4 clocks per bit.

## Interface
- No parameters; the bit period is fixed at 4 clocks.
- `clk`  in  1  48 MHz clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_pkt_start`  in  1  one-cycle strobe that starts a packet.
- `tx_pid`  in  4  PID, sampled with `tx_pkt_start`.
- `tx_data_avail`  in  1  a payload byte is available on `tx_data`.
- `tx_data`  in  8  payload byte, valid while `tx_data_avail` is high.
- `tx_data_get`  out  1  one-cycle pulse that consumes the current byte.
- `tx_pkt_end`  out  1  one-cycle pulse when the packet is fully on the line.
- `usb_p_tx`, `usb_n_tx`  out  1 each  differential line levels.
- `usb_tx_en`  out  1  output enable for the transceiver.

## Operation
- Reset values: `usb_p_tx`=1, `usb_n_tx`=0 (J), `usb_tx_en`=0, `tx_data_get`=0, `tx_pkt_end`=0. The FSM resets to IDLE.
- FSM states: IDLE → SYNC → PID → (DATA → CRC_LO → CRC_HI)? → EOP → IDLE.
- IDLE:
  - `tx_pkt_start` latches `tx_pid` and goes to SYNC.
  - `tx_pkt_start` in any other state is ignored.
- SYNC: 8 bits, 0x80 sent LSB-first (KJKJKJKK on the line).
- PID: byte `{~tx_pid, tx_pid}`, LSB-first.
- Packet type:
  - `tx_pid[1:0]==2'b11` (DATA0/1) enters DATA.
  - Any other PID (handshake, STALL) goes straight to EOP.
- DATA, at each byte boundary (after the PID or after a data byte):
  - If `tx_data_avail`: capture `tx_data` and pulse `tx_data_get` in the same cycle.
  - Otherwise go to CRC_LO.
- CRC16:
  - Polynomial 0x8005, init 0xFFFF, updated LSB-first over payload bits only.
  - On the wire: the complement, low byte then high byte, LSB-first.
  - A zero-length packet sends 0x00, 0x00.
- Bit stuffing:
  - A 0 is inserted after six consecutive 1s.
  - The run counter resets at packet start and spans PID, DATA and CRC.
  - A stuff bit owed after the last CRC bit is sent before EOP.
  - Stuff bits do not enter the CRC.
- NRZI: data 0 toggles the line state; data 1 holds it. The line starts from J.
- EOP: SE0 (`usb_p_tx`=`usb_n_tx`=0) for 2 bit times, then J for 1 bit time. Then `tx_pkt_end` pulses and `usb_tx_en` drops.
- Reset mid-packet aborts immediately to IDLE with the reset values. No EOP and no `tx_pkt_end` are produced.

## Timing
- Bit timer: a 2-bit counter that restarts when leaving IDLE. Each line bit is held exactly 4 clocks.
- Start latency: `tx_pkt_start` at cycle 0 → `usb_tx_en`=1 and the first SYNC bit (K) at cycle 1.
- ACK (PID 0x2) packet is 19 bits = 76 cycles:
  - `usb_tx_en` is high for cycles 1–76.
  - `tx_pkt_end` pulses at cycle 76.
  - `usb_tx_en`=0 at cycle 77.
- Byte fetch:
  - `tx_data_get` fires in the last clock of the preceding byte's final bit (stuff bit included).
  - Fetches are at least 32 clocks apart. This satisfies the upstream rule that `tx_data` is valid 2 cycles after a get.
- `tx_data_avail` is combinational upstream and is sampled only at byte boundaries.

## Configuration
- `USB_FS_TX_TURNAROUND_EN` defined:
  - A `tx_pkt_start` arriving within 8 cycles (2 bit times) after the cycle `usb_tx_en` falls is latched with its PID.
  - SYNC begins once 8 idle cycles have elapsed.
  - `usb_tx_en` rises on the first cycle after the gap.
- Undefined: no gap is enforced; start latency is always 1 cycle.

## Test plan
- ACK (`tx_pid`=4'h2):
  - Decoded bits: SYNC 0x80, then 0xD2.
  - 76 enabled cycles, `tx_pkt_end` at cycle 76.
  - No `tx_data_get`.
- DATA1 (4'hB) with `tx_data_avail`=0: PID byte 0x4B, CRC bytes 0x00 0x00, zero `tx_data_get` pulses.
- DATA0 (4'h3) with payload 0xFF,0xFF:
  - Stuff bits appear after every 6 ones.
  - A bench decoder (destuff + NRZI) recovers 0xFF 0xFF.
  - CRC residual over payload+CRC equals 0x800D.
  - Exactly 2 `tx_data_get` pulses, spaced ≥32 cycles apart.
- Random 0–32 byte payloads from a model of the IN engine's registered read: decoded bytes match, and the CRC residual is 0x800D.
- Drop `reset_n` during the DATA state: outputs go to J with `usb_tx_en`=0 immediately, no `tx_pkt_end`. The next ACK then transmits normally.
- With `USB_FS_TX_TURNAROUND_EN`: `tx_pkt_start` 2 cycles after `usb_tx_en` falls → `usb_tx_en` rises 8 cycles after the fall. Without the macro → it rises 1 cycle after the start.

Source files
------------

// File: rtl/usb_fs_tx_serializer_if.sv
// rtl/usb_fs_tx_serializer_if.sv - packet/payload handshake between the IN engine and the FS transmit serializer
interface usb_fs_tx_serializer_if;
  logic       tx_pkt_start;
  logic [3:0] tx_pid;
  logic       tx_data_avail;
  logic [7:0] tx_data;
  logic       tx_data_get;
  logic       tx_pkt_end;

  modport master (
    output tx_pkt_start, tx_pid, tx_data_avail, tx_data,
    input  tx_data_get, tx_pkt_end
  );

  modport slave (
    input  tx_pkt_start, tx_pid, tx_data_avail, tx_data,
    output tx_data_get, tx_pkt_end
  );
endinterface

// File: rtl/usb_fs_tx_serializer.sv
// rtl/usb_fs_tx_serializer.sv - full-speed USB TX: SYNC/PID/payload/CRC16, bit stuffing, NRZI, EOP at 4 clk/bit
// Optional USB_FS_TX_TURNAROUND_EN enforces an 8-cycle idle gap before a new packet.
module usb_fs_tx_serializer (
  input  logic                   clk,
  input  logic                   reset_n,
  usb_fs_tx_serializer_if.slave  tx_if,
  output logic                   usb_p_tx,
  output logic                   usb_n_tx,
  output logic                   usb_tx_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  ones_q, ones_d;
  logic        stuff_q, stuff_d;
  logic [15:0] crc_q, crc_d;
  logic [3:0]  pid_q, pid_d;
  logic        line_j_q, line_j_d;
  logic        se0_q, se0_d;
  logic        tx_en_q, tx_en_d;

  logic bit_end, cur_data, need_stuff, byte_done, is_data_pkt, fetch, start_go, next_bit;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction

  // CRC leaves the register MSB first; reversing lets it share the LSB-first shifter.
  function automatic logic [7:0] rev_inv(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev_inv[i] = ~v[7-i];
  endfunction

  assign bit_end     = (state_q != S_IDLE) && (bit_cnt_q == 2'd3);
  assign cur_data    = (state_q inside {S_PID, S_DATA, S_CRC_LO, S_CRC_HI}) && !stuff_q;
  assign need_stuff  = cur_data && shift_q[0] && (ones_q == 3'd5);
  assign byte_done   = stuff_q ? (bit_idx_q == 3'd0) : ((bit_idx_q == 3'd7) && !need_stuff);
  assign is_data_pkt = (pid_q[1:0] == 2'b11);
  assign fetch       = bit_end && byte_done && tx_if.tx_data_avail &&
                       ((state_q == S_PID && is_data_pkt) || state_q == S_DATA);

`ifdef USB_FS_TX_TURNAROUND_EN
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       pend_q, pend_d;

  assign start_go = (state_q == S_IDLE) && (tx_if.tx_pkt_start || pend_q) && (idle_cnt_q >= 4'd7);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    pend_d     = pend_q;
    if (state_q == S_IDLE) begin
      if (idle_cnt_q != 4'd8) idle_cnt_d = idle_cnt_q + 4'd1;
      pend_d = (pend_q || tx_if.tx_pkt_start) && !start_go;
    end else begin
      pend_d = 1'b0;
      if (state_d == S_IDLE) idle_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= 4'd8;
      pend_q     <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      pend_q     <= pend_d;
    end
  end
`else
  assign start_go = (state_q == S_IDLE) && tx_if.tx_pkt_start;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_go) state_d = S_SYNC;
      S_SYNC:   if (bit_end && byte_done) state_d = S_PID;
      S_PID:    if (bit_end && byte_done)
                  state_d = !is_data_pkt ? S_EOP : (tx_if.tx_data_avail ? S_DATA : S_CRC_LO);
      S_DATA:   if (bit_end && byte_done) state_d = tx_if.tx_data_avail ? S_DATA : S_CRC_LO;
      S_CRC_LO: if (bit_end && byte_done) state_d = S_CRC_HI;
      S_CRC_HI: if (bit_end && byte_done) state_d = S_EOP;
      S_EOP:    if (bit_end && bit_idx_q == 3'd2) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d = (state_q == S_IDLE) ? 2'd0 : bit_cnt_q + 2'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ones_d    = ones_q;
    stuff_d   = stuff_q;
    crc_d     = crc_q;
    pid_d     = pid_q;
    line_j_d  = line_j_q;
    se0_d     = se0_q;
    tx_en_d   = tx_en_q;
    next_bit  = 1'b1;
    if (state_q == S_IDLE) begin
      if (tx_if.tx_pkt_start) pid_d = tx_if.tx_pid;
      if (start_go) begin
        shift_d   = 8'h80;
        bit_idx_d = 3'd0;
        ones_d    = 3'd0;
        stuff_d   = 1'b0;
        crc_d     = 16'hFFFF;
        line_j_d  = 1'b0;
        se0_d     = 1'b0;
        tx_en_d   = 1'b1;
      end
    end else if (bit_end) begin
      if (state_q == S_EOP) begin
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd1) begin
          se0_d    = 1'b0;
          line_j_d = 1'b1;
        end
        if (bit_idx_q == 3'd2) begin
          bit_idx_d = 3'd0;
          tx_en_d   = 1'b0;
        end
      end else begin
        if (cur_data) ones_d = shift_q[0] ? ones_q + 3'd1 : 3'd0;
        if (state_q == S_DATA && !stuff_q) crc_d = crc_step(crc_q, shift_q[0]);
        // A stuff bit holds the shifter so the owed data bit follows it.
        if (!stuff_q) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
        stuff_d = need_stuff;
        if (need_stuff) ones_d = 3'd0;
        next_bit = need_stuff ? 1'b0 : shift_d[0];
        if (byte_done) begin
          bit_idx_d = 3'd0;
          case (state_d)
            S_PID:    shift_d = {~pid_q, pid_q};
            S_DATA:   shift_d = tx_if.tx_data;
            S_CRC_LO: shift_d = rev_inv(crc_d[15:8]);
            S_CRC_HI: shift_d = rev_inv(crc_d[7:0]);
            default:  shift_d = shift_q;
          endcase
          next_bit = shift_d[0];
          if (state_d == S_EOP) se0_d = 1'b1;
        end
        if (state_d != S_EOP) line_j_d = next_bit ? line_j_q : !line_j_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= 2'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      ones_q    <= 3'd0;
      stuff_q   <= 1'b0;
      crc_q     <= 16'hFFFF;
      pid_q     <= 4'h0;
      line_j_q  <= 1'b1;
      se0_q     <= 1'b0;
      tx_en_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ones_q    <= ones_d;
      stuff_q   <= stuff_d;
      crc_q     <= crc_d;
      pid_q     <= pid_d;
      line_j_q  <= line_j_d;
      se0_q     <= se0_d;
      tx_en_q   <= tx_en_d;
    end
  end

  always_comb begin
    tx_if.tx_data_get = fetch;
    tx_if.tx_pkt_end  = (state_q == S_EOP) && bit_end && (bit_idx_q == 3'd2);
    usb_p_tx          = line_j_q & ~se0_q;
    usb_n_tx          = ~line_j_q & ~se0_q;
    usb_tx_en         = tx_en_q;
  end

endmodule

// File: tb/tb_usb_fs_tx_serializer.sv
// tb/tb_usb_fs_tx_serializer.sv - directed bench: line decoder, upstream read model, byte scoreboard
module tb_usb_fs_tx_serializer;
  logic clk, reset_n;
  logic usb_p_tx, usb_n_tx, usb_tx_en;

  usb_fs_tx_serializer_if tif();

  usb_fs_tx_serializer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_if     (tif),
    .usb_p_tx  (usb_p_tx),
    .usb_n_tx  (usb_n_tx),
    .usb_tx_en (usb_tx_en)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_cycles = 0;
  int en_base, c0, stuff_err, eop_ok;

  logic [1:0] sym_q[$];
  logic [7:0] up_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  logic [7:0] pay[$];
  int get_cyc_q[$], end_cyc_q[$], rise_cyc_q[$], stuff_pos_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: one symbol per bit, sampled in the second clock of each bit.
  initial begin : line_mon
    logic [1:0] phase;
    logic       prev_en;
    phase = 2'd0;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (usb_tx_en === 1'b1) begin
        en_cycles++;
        if (!prev_en) rise_cyc_q.push_back(cyc);
        if (phase == 2'd1) sym_q.push_back({usb_p_tx, usb_n_tx});
        phase = phase + 2'd1;
      end else begin
        phase = 2'd0;
      end
      prev_en = (usb_tx_en === 1'b1);
      if (tif.tx_data_get === 1'b1) get_cyc_q.push_back(cyc);
      if (tif.tx_pkt_end === 1'b1) end_cyc_q.push_back(cyc);
    end
  end

  // IN engine registered read: next byte shows up two cycles after a get.
  initial begin : upstream
    logic g, hold;
    hold = 1'b0;
    tif.tx_data_avail = 1'b0;
    tif.tx_data = 8'h00;
    forever begin
      @(negedge clk);
      g = (tif.tx_data_get === 1'b1);
      @(posedge clk);
      #1;
      if (g) begin
        if (up_q.size() > 0) void'(up_q.pop_front());
        tif.tx_data_avail = 1'b0;
        tif.tx_data = 8'h5A;
        hold = 1'b1;
      end else if (hold) begin
        hold = 1'b0;
      end else begin
        tif.tx_data_avail = (up_q.size() > 0);
        tif.tx_data = (up_q.size() > 0) ? up_q[0] : 8'h00;
      end
    end
  end

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    crc_bit = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction

  task automatic decode();
    logic [1:0] prev, s;
    logic [7:0] cur;
    logic b;
    int ones, nbits, se0n;
    dec_q.delete();
    stuff_pos_q.delete();
    prev = 2'b10; cur = 8'h00; ones = 0; nbits = 0; se0n = 0;
    eop_ok = 0; stuff_err = 0;
    for (int i = 0; i < sym_q.size(); i++) begin
      s = sym_q[i];
      if (s == 2'b00) begin
        se0n++;
        continue;
      end
      if (se0n > 0) begin
        eop_ok = (se0n == 2 && s == 2'b10 && i == sym_q.size() - 1) ? 1 : 0;
        break;
      end
      b = (s == prev);
      prev = s;
      if (nbits >= 8 && ones == 6) begin
        stuff_pos_q.push_back(nbits - 8);
        if (b) stuff_err++;
        ones = 0;
        continue;
      end
      cur = {b, cur[7:1]};
      nbits++;
      if (nbits > 8) ones = b ? ones + 1 : 0;
      if (nbits % 8 == 0) dec_q.push_back(cur);
    end
  endtask

  task automatic start_pkt(input logic [3:0] pid, input bit track);
    sym_q.delete(); get_cyc_q.delete(); end_cyc_q.delete(); rise_cyc_q.delete();
    if (track) begin
      exp_q.push_back(8'h80);
      exp_q.push_back({~pid, pid});
    end
    if (pid[1:0] == 2'b11) begin
      foreach (pay[i]) begin
        up_q.push_back(pay[i]);
        if (track) exp_q.push_back(pay[i]);
      end
    end
    @(posedge clk); #1;
    tif.tx_pkt_start = 1'b1;
    tif.tx_pid = pid;
    c0 = cyc;
    en_base = en_cycles;
    @(posedge clk); #1;
    tif.tx_pkt_start = 1'b0;
    tif.tx_pid = 4'h0;
  endtask

  task automatic wait_end(input int budget);
    int t;
    t = 0;
    while (end_cyc_q.size() == 0 && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    chk("pkt_end_seen", (end_cyc_q.size() > 0) ? 1 : 0, 1);
  endtask

  task automatic check_pkt(input logic [3:0] pid, input int n);
    logic [7:0] exp_b, obs_b, byte_v;
    logic [15:0] r;
    int nb;
    decode();
    nb = (pid[1:0] == 2'b11) ? n + 4 : 2;
    chk("byte_count", dec_q.size(), nb);
    chk("eop_shape", eop_ok, 1);
    chk("stuff_bit_zero", stuff_err, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp_b = exp_q.pop_front();
      obs_b = (i < dec_q.size()) ? dec_q[i] : 8'hxx;
      chk($sformatf("byte%0d", i), obs_b, exp_b);
    end
    if (pid[1:0] == 2'b11) begin
      r = 16'hFFFF;
      for (int i = 2; i < dec_q.size(); i++) begin
        byte_v = dec_q[i];
        for (int k = 0; k < 8; k++) r = crc_bit(r, byte_v[k]);
      end
      chk("crc_residual", r, 16'h800D);
      chk("get_count", get_cyc_q.size(), n);
      for (int i = 1; i < get_cyc_q.size(); i++)
        chk("get_spacing", ((get_cyc_q[i] - get_cyc_q[i-1]) >= 32) ? 1 : 0, 1);
    end else begin
      chk("get_count", get_cyc_q.size(), 0);
    end
    chk("end_count", end_cyc_q.size(), 1);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t, n, e_a, rise_exp;
    reset_n = 1'b0;
    tif.tx_pkt_start = 1'b0;
    tif.tx_pid = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p", usb_p_tx, 1);
    chk("rst_n", usb_n_tx, 0);
    chk("rst_en", usb_tx_en, 0);
    chk("rst_get", tif.tx_data_get, 0);
    chk("rst_end", tif.tx_pkt_end, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // ACK: exact framing and timing
    pay.delete();
    start_pkt(4'h2, 1'b1);
    wait_end(400);
    check_pkt(4'h2, 0);
    chk("ack_rise", rise_cyc_q.size() > 0 ? rise_cyc_q[0] : -1, c0 + 1);
    chk("ack_end_cycle", end_cyc_q.size() > 0 ? end_cyc_q[0] : -1, c0 + 76);
    chk("ack_en_cycles", en_cycles - en_base, 76);
    @(negedge clk); #1;
    chk("ack_en_off", usb_tx_en, 0);

    // DATA1, zero length
    repeat (5) @(posedge clk);
    pay.delete();
    start_pkt(4'hB, 1'b1);
    wait_end(600);
    check_pkt(4'hB, 0);
    chk("zlp_crc_lo", dec_q.size() > 2 ? dec_q[2] : 8'hxx, 8'h00);
    chk("zlp_crc_hi", dec_q.size() > 3 ? dec_q[3] : 8'hxx, 8'h00);

    // DATA0 with 0xFF 0xFF: stuffing after every six ones
    repeat (5) @(posedge clk);
    pay.delete();
    pay.push_back(8'hFF);
    pay.push_back(8'hFF);
    start_pkt(4'h3, 1'b1);
    wait_end(800);
    check_pkt(4'h3, 2);
    chk("stuff_pos0", stuff_pos_q.size() > 0 ? stuff_pos_q[0] : -1, 12);
    chk("stuff_pos1", stuff_pos_q.size() > 1 ? stuff_pos_q[1] : -1, 18);
    chk("stuff_pos2", stuff_pos_q.size() > 2 ? stuff_pos_q[2] : -1, 24);

    // Random payloads
    for (int p = 0; p < 4; p++) begin
      repeat (5) @(posedge clk);
      n = (p == 0) ? 32 : $urandom_range(0, 32);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
      start_pkt((p % 2 == 0) ? 4'h3 : 4'hB, 1'b1);
      wait_end(4000);
      check_pkt((p % 2 == 0) ? 4'h3 : 4'hB, n);
    end

    // Reset while in DATA
    repeat (5) @(posedge clk);
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(8'h11 * (i + 1));
    start_pkt(4'h3, 1'b0);
    t = 0;
    while (get_cyc_q.size() == 0 && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    chk("abort_reached_data", (get_cyc_q.size() > 0) ? 1 : 0, 1);
    repeat (6) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_p", usb_p_tx, 1);
    chk("abort_n", usb_n_tx, 0);
    chk("abort_en", usb_tx_en, 0);
    repeat (20) @(negedge clk);
    #1;
    chk("abort_no_end", end_cyc_q.size(), 0);
    chk("abort_en_held", usb_tx_en, 0);
    reset_n = 1'b1;
    up_q.delete();
    repeat (4) @(posedge clk);

    pay.delete();
    start_pkt(4'h2, 1'b1);
    wait_end(400);
    check_pkt(4'h2, 0);
    chk("post_abort_end_cycle", end_cyc_q.size() > 0 ? end_cyc_q[0] : -1, c0 + 76);

    // Turnaround: start two cycles after usb_tx_en falls
    repeat (5) @(posedge clk);
    start_pkt(4'h2, 1'b1);
    wait_end(400);
    check_pkt(4'h2, 0);
    e_a = end_cyc_q.size() > 0 ? end_cyc_q[0] : 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_pkt(4'h2, 1'b1);
`ifdef USB_FS_TX_TURNAROUND_EN
    rise_exp = e_a + 1 + 8;
`else
    rise_exp = e_a + 1 + 3;
`endif
    wait_end(400);
    chk("turnaround_rise", rise_cyc_q.size() > 0 ? rise_cyc_q[0] : -1, rise_exp);
    check_pkt(4'h2, 0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
